// File: rtl/apb_spi_master.sv
// APB slave SPI master: register file plus a single-byte, full-duplex mode-0 shift engine.
// SCLK half-period is CLKDIV+1 clk cycles; a transfer spans 16 half-periods.
module apb_spi_master #(
  parameter logic [7:0] DIV_RESET = 8'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [2:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_ss_n,
  output logic       spi_irq
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t      state;
  logic [3:0]  ctrl;
  logic        rx_valid;
  logic        ovr;
  logic [7:0]  rxdata;
  logic [7:0]  clkdiv;
  logic [7:0]  div_cnt;
  logic [3:0]  edge_cnt;
  logic [7:0]  tx_shift;
  logic [7:0]  rx_shift;

  logic acc, wr, rd, busy, en, lsb_first;
  logic tx_go, div_wr, abort, rx_rd, tick;

  assign acc       = PSEL & PENABLE;
  assign wr        = acc & PWRITE;
  assign rd        = acc & ~PWRITE;
  assign busy      = (state == XFER);
  assign en        = ctrl[0];
  assign lsb_first = ctrl[2];
  assign tx_go     = wr && (PADDR == 3'd2) && en && !busy;
  assign div_wr    = wr && (PADDR == 3'd4) && !busy;
  assign abort     = wr && (PADDR == 3'd0) && busy && !PWDATA[0];
  assign rx_rd     = rd && (PADDR == 3'd3);
  assign tick      = (div_cnt == clkdiv);

  assign PREADY   = 1'b1;
  assign spi_ss_n = ~ctrl[1];

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  always_comb begin
    PRDATA = '0;
    if (PSEL) begin
      case (PADDR)
        3'd0:    PRDATA = {4'b0000, ctrl};
        3'd1:    PRDATA = {5'b00000, ovr, rx_valid, busy};
        3'd3:    PRDATA = rxdata;
        3'd4:    PRDATA = clkdiv;
        default: PRDATA = '0;
      endcase
    end
  end

  always_comb begin
    PSLVERR = 1'b0;
    if (acc) begin
      if (PADDR >= 3'd5)
        PSLVERR = 1'b1;
      else if (PWRITE && (PADDR == 3'd2) && (busy || !en))
        PSLVERR = 1'b1;
      else if (PWRITE && (PADDR == 3'd4) && busy)
        PSLVERR = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ctrl     <= '0;
      rx_valid <= 1'b0;
      ovr      <= 1'b0;
      rxdata   <= '0;
      clkdiv   <= DIV_RESET;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      spi_irq  <= 1'b0;
    end else begin
      if (wr && (PADDR == 3'd0)) ctrl <= PWDATA[3:0];
      if (div_wr) clkdiv <= PWDATA;
      if (rx_rd) rx_valid <= 1'b0;
      if (wr && (PADDR == 3'd1) && PWDATA[2]) ovr <= 1'b0;
      spi_irq <= ctrl[3] & (rx_valid | ovr);

      // DONE is placed after the clears so a commit overrides a same-cycle read or W1C.
      case (state)
        XFER: begin
          if (abort) begin
            state    <= IDLE;
            spi_sclk <= 1'b0;
            div_cnt  <= '0;
            edge_cnt <= '0;
          end else if (tick) begin
            div_cnt  <= '0;
            spi_sclk <= ~spi_sclk;
            edge_cnt <= edge_cnt + 4'd1;
            if (!spi_sclk) begin
              rx_shift <= {rx_shift[6:0], spi_miso};
            end else if (edge_cnt != 4'd15) begin
              if (lsb_first) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                spi_mosi <= tx_shift[1];
              end else begin
                tx_shift <= {tx_shift[6:0], 1'b0};
                spi_mosi <= tx_shift[6];
              end
            end
            if (edge_cnt == 4'd15) state <= DONE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        DONE: begin
          rxdata   <= lsb_first ? rev8(rx_shift) : rx_shift;
          rx_valid <= 1'b1;
          if (rx_valid && !rx_rd) ovr <= 1'b1;
          state <= IDLE;
        end
        default: ;
      endcase

      if (tx_go) begin
        tx_shift <= PWDATA;
        spi_mosi <= lsb_first ? PWDATA[0] : PWDATA[7];
        div_cnt  <= '0;
        edge_cnt <= '0;
        spi_sclk <= 1'b0;
        state    <= XFER;
      end
    end
  end

endmodule
